// File: rtl/cam_sim_pkg.sv
// Shared definitions for the camera pattern generator: pattern mode codes,
// frame FSM state encoding and the RGB565 colour-bar table.
package cam_sim_pkg;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_RAMP  = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } cam_state_e;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [15:0] BAR_TABLE [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/camera_pattern_gen_if.sv
// Camera-side bus of the pattern generator: pixel clock, syncs, byte data
// and the frame status strobes.
interface camera_pattern_gen_if;
  logic       cam_pclk;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_data;
  logic       frame_start;
  logic       busy;

  modport master (
    output cam_pclk, cam_vsync, cam_href, cam_data, frame_start, busy
  );

  modport slave (
    input cam_pclk, cam_vsync, cam_href, cam_data, frame_start, busy
  );
endinterface

// File: rtl/cam_pattern_lut.sv
// Combinational test-pattern source: maps (mode, pixel x, bit 3 of line y,
// latched solid colour) to one RGB565 pixel.
module cam_pattern_lut
  import cam_sim_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_x,
  input  logic        i_y_b3,
  input  logic [15:0] i_color,
  output logic [15:0] o_pix
);

  logic [2:0] w_bar;

  // Select the pixel value for the current mode; the bar index is
  // multiply-then-divide in 20 bits so wide lines never overflow.
  always_comb begin
    w_bar = 3'(({4'b0000, i_x} << 3) / 20'(H_ACTIVE));
    o_pix = 16'h0000;
    case (i_mode)
      MODE_SOLID: o_pix = i_color;
      MODE_BARS:  o_pix = bar_color(w_bar);
      MODE_RAMP:  o_pix = i_x;
      MODE_CHECK: o_pix = (i_x[3] ^ i_y_b3) ? 16'hFFFF : 16'h0000;
      default:    o_pix = 16'h0000;
    endcase
  end

endmodule

// File: rtl/camera_pattern_gen.sv
// OV7670-style camera source: divided pixel clock, VSYNC/HREF framing and
// RGB565 or mono byte data. Framing advances only on pclk falling edges so
// data is stable half a pclk period before each rising edge.
module camera_pattern_gen
  import cam_sim_pkg::*;
#(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int H_BLANK       = 144,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BACK        = 17,
  parameter int V_FRONT       = 10,
  parameter int BYTES_PER_PIX = 2,
  parameter int CLK_DIV       = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [15:0]                solid_color,
  camera_pattern_gen_if.master       bus
);

  localparam int ACT_BYTES = H_ACTIVE * BYTES_PER_PIX;
  localparam int LINE_LEN  = ACT_BYTES + H_BLANK;
  localparam int HW        = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int VMAX_A    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int VMAX_B    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX      = (VMAX_A > VMAX_B) ? VMAX_A : VMAX_B;
  localparam int VW        = $clog2(VMAX + 1);
  localparam int DW        = $clog2(CLK_DIV);

  logic [DW-1:0] r_div;
  cam_state_e    r_state, w_state_nxt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic [VW-1:0] r_vcnt, w_vcnt_nxt;
  logic [1:0]    r_mode, w_mode_nxt;
  logic [15:0]   r_color, w_color_nxt;
  logic          r_fs, w_fs_nxt;

  logic          w_tick;
  logic          w_hwrap;
  logic          w_vlast;
  logic          w_start;
  logic [VW-1:0] w_len_last;
  logic          w_href;
  logic          w_lo;
  logic          w_y_b3;
  logic [15:0]   w_x;
  logic [15:0]   w_pix;

  // The last divider count is the clk cycle whose closing edge drops pclk.
  assign w_tick  = (r_div == DW'(CLK_DIV - 1));
  assign w_hwrap = (r_hcnt == HW'(LINE_LEN - 1));
  assign w_vlast = (r_vcnt == w_len_last);

  // Free-running pixel clock divider, independent of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div <= '0;
    else        r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  // Number of lines (minus one) spent in the current frame phase.
  always_comb begin
    w_len_last = '0;
    case (r_state)
      ST_VSYNC:  w_len_last = VW'(VSYNC_LINES - 1);
      ST_VBACK:  w_len_last = VW'(V_BACK - 1);
      ST_ACTIVE: w_len_last = VW'(V_ACTIVE - 1);
      ST_VFRONT: w_len_last = VW'(V_FRONT - 1);
      default:   w_len_last = '0;
    endcase
  end

  // Frame FSM next-state: counters move on fall ticks only; en is checked
  // only in IDLE and at the end of the front porch, where a new frame
  // relatches mode and colour.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_vcnt_nxt  = r_vcnt;
    w_mode_nxt  = r_mode;
    w_color_nxt = r_color;
    w_fs_nxt    = 1'b0;
    w_start     = 1'b0;
    if (w_tick) begin
      if (r_state == ST_IDLE) begin
        w_start = en;
      end else begin
        w_hcnt_nxt = w_hwrap ? '0 : r_hcnt + 1'b1;
        if (w_hwrap) begin
          w_vcnt_nxt = w_vlast ? '0 : r_vcnt + 1'b1;
          if (w_vlast) begin
            case (r_state)
              ST_VSYNC:  w_state_nxt = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
              ST_VBACK:  w_state_nxt = ST_ACTIVE;
              ST_ACTIVE: begin
                if (V_FRONT > 0) begin
                  w_state_nxt = ST_VFRONT;
                end else begin
                  w_state_nxt = ST_IDLE;
                  w_start     = en;
                end
              end
              ST_VFRONT: begin
                w_state_nxt = ST_IDLE;
                w_start     = en;
              end
              default:   w_state_nxt = ST_IDLE;
            endcase
          end
        end
      end
      if (w_start) begin
        w_state_nxt = ST_VSYNC;
        w_hcnt_nxt  = '0;
        w_vcnt_nxt  = '0;
        w_mode_nxt  = mode;
        w_color_nxt = solid_color;
        w_fs_nxt    = 1'b1;
      end
    end
  end

  // Frame FSM state, counters and latched pattern settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_mode  <= 2'd0;
      r_color <= 16'h0000;
      r_fs    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
      r_mode  <= w_mode_nxt;
      r_color <= w_color_nxt;
      r_fs    <= w_fs_nxt;
    end
  end

  assign w_href = (r_state == ST_ACTIVE) && (r_hcnt < HW'(ACT_BYTES));
  assign w_x    = 16'(r_hcnt >> (BYTES_PER_PIX - 1));
  assign w_lo   = (BYTES_PER_PIX == 2) && r_hcnt[0];
  assign w_y_b3 = |(r_vcnt & VW'(8));

  cam_pattern_lut #(
    .H_ACTIVE (H_ACTIVE)
  ) u_lut (
    .i_mode  (r_mode),
    .i_x     (w_x),
    .i_y_b3  (w_y_b3),
    .i_color (r_color),
    .o_pix   (w_pix)
  );

  assign bus.cam_pclk    = (r_div >= DW'(CLK_DIV / 2));
  assign bus.cam_vsync   = (r_state == ST_VSYNC);
  assign bus.cam_href    = w_href;
  assign bus.cam_data    = w_href ? (w_lo ? w_pix[7:0] : w_pix[15:8]) : 8'h00;
  assign bus.frame_start = r_fs;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_camera_pattern_gen.sv
// Bench for camera_pattern_gen: two geometries driven from shared inputs and
// checked every clk against a frame-position reference model.
module tb_camera_pattern_gen;

  localparam int G_HA  [2] = '{8, 16};
  localparam int G_VA  [2] = '{4, 16};
  localparam int G_HB  [2] = '{4, 4};
  localparam int G_VS  [2] = '{1, 1};
  localparam int G_VB  [2] = '{1, 1};
  localparam int G_VF  [2] = '{1, 1};
  localparam int G_BPP [2] = '{2, 2};
  localparam int G_DIV [2] = '{2, 4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] solid_color;

  always #5 clk = ~clk;

  camera_pattern_gen_if bus_a ();
  camera_pattern_gen_if bus_b ();

  camera_pattern_gen #(
    .H_ACTIVE(G_HA[0]), .V_ACTIVE(G_VA[0]), .H_BLANK(G_HB[0]),
    .VSYNC_LINES(G_VS[0]), .V_BACK(G_VB[0]), .V_FRONT(G_VF[0]),
    .BYTES_PER_PIX(G_BPP[0]), .CLK_DIV(G_DIV[0])
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .solid_color(solid_color), .bus(bus_a)
  );

  camera_pattern_gen #(
    .H_ACTIVE(G_HA[1]), .V_ACTIVE(G_VA[1]), .H_BLANK(G_HB[1]),
    .VSYNC_LINES(G_VS[1]), .V_BACK(G_VB[1]), .V_FRONT(G_VF[1]),
    .BYTES_PER_PIX(G_BPP[1]), .CLK_DIV(G_DIV[1])
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .solid_color(solid_color), .bus(bus_b)
  );

  int total = 0;
  int bad   = 0;

  // reference model: divider phase, running flag, pclk index within frame
  int          m_cnt  [2];
  int          m_p    [2];
  bit          m_run  [2];
  bit          m_fs   [2];
  logic [1:0]  m_mode [2];
  logic [15:0] m_col  [2];

  logic [7:0] cap0 [$];
  logic [7:0] cap1 [$];
  logic       prev_pclk [2];
  int cnt_fs, cnt_vs, cnt_href, cnt_tog;

  logic [7:0] bars_lit [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  function automatic logic [15:0] bar_ref(int b);
    case (b)
      0: return 16'hFFFF;  1: return 16'hFFE0;  2: return 16'h07FF;  3: return 16'h07E0;
      4: return 16'hF81F;  5: return 16'hF800;  6: return 16'h001F;  default: return 16'h0000;
    endcase
  endfunction

  function automatic int line_len(int d);
    return G_HA[d] * G_BPP[d] + G_HB[d];
  endfunction

  function automatic int frame_len(int d);
    return line_len(d) * (G_VS[d] + G_VB[d] + G_VA[d] + G_VF[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_p[d] = 0; m_run[d] = 0; m_fs[d] = 0;
      m_mode[d] = 2'd0; m_col[d] = 16'h0000;
    end
  endtask

  // effect of one rising clk edge given the inputs currently applied
  task automatic model_adv();
    bit fall;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      fall     = (m_cnt[d] == G_DIV[d] - 1);
      m_cnt[d] = (m_cnt[d] + 1) % G_DIV[d];
      m_fs[d]  = 0;
      if (fall) begin
        if (m_run[d]) begin
          m_p[d]++;
          if (m_p[d] == frame_len(d)) begin
            m_run[d] = 0;
            m_p[d]   = 0;
          end
        end
        if (!m_run[d] && en) begin
          m_run[d] = 1; m_p[d] = 0; m_fs[d] = 1;
          m_mode[d] = mode; m_col[d] = solid_color;
        end
      end
    end
  endtask

  // {pclk, vsync, href, frame_start, busy, data}
  function automatic logic [12:0] expect_out(int d);
    int L, line, h, a, x, y;
    logic [15:0] pix;
    logic pc, vs, hr;
    logic [7:0] dat;
    L = line_len(d);
    pc = (m_cnt[d] >= G_DIV[d] / 2);
    vs = 0; hr = 0; dat = 8'h00; pix = 16'h0000;
    if (m_run[d]) begin
      line = m_p[d] / L;
      h    = m_p[d] % L;
      vs   = (line < G_VS[d]);
      a    = line - G_VS[d] - G_VB[d];
      if (a >= 0 && a < G_VA[d] && h < G_HA[d] * G_BPP[d]) begin
        hr = 1;
        x  = h / G_BPP[d];
        y  = a;
        case (m_mode[d])
          2'd0: pix = m_col[d];
          2'd1: pix = bar_ref(x * 8 / G_HA[d]);
          2'd2: pix = 16'(x);
          default: pix = (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
        endcase
        dat = (G_BPP[d] == 2 && (h % 2) == 1) ? pix[7:0] : pix[15:8];
      end
    end
    return {pc, vs, hr, m_fs[d], m_run[d], dat};
  endfunction

  function automatic logic [12:0] get_out(int d);
    if (d == 0)
      return {bus_a.cam_pclk, bus_a.cam_vsync, bus_a.cam_href, bus_a.frame_start,
              bus_a.busy, bus_a.cam_data};
    return {bus_b.cam_pclk, bus_b.cam_vsync, bus_b.cam_href, bus_b.frame_start,
            bus_b.busy, bus_b.cam_data};
  endfunction

  function automatic logic [7:0] capb(int d, int idx);
    if (d == 0) return (idx < cap0.size()) ? cap0[idx] : 8'hxx;
    return (idx < cap1.size()) ? cap1[idx] : 8'hxx;
  endfunction

  task automatic chk(string name, int d, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, d, $time, act, exp);
    end
  endtask

  task automatic cmp_all();
    logic [12:0] o, e;
    for (int d = 0; d < 2; d++) begin
      o = get_out(d);
      e = expect_out(d);
      chk("pclk", d, 16'(o[12]), 16'(e[12]));
      chk("vsync", d, 16'(o[11]), 16'(e[11]));
      chk("href", d, 16'(o[10]), 16'(e[10]));
      chk("frame_start", d, 16'(o[9]), 16'(e[9]));
      chk("busy", d, 16'(o[8]), 16'(e[8]));
      chk("data", d, 16'(o[7:0]), 16'(e[7:0]));
    end
  endtask

  task automatic clr_cnt();
    cnt_fs = 0; cnt_vs = 0; cnt_href = 0; cnt_tog = 0;
  endtask

  // one clk: advance the model for the coming edge, then check on the falling edge
  task automatic cyc();
    logic [12:0] o;
    model_adv();
    @(negedge clk);
    cmp_all();
    for (int d = 0; d < 2; d++) begin
      o = get_out(d);
      if (o[9]) begin
        if (d == 0) cap0.delete(); else cap1.delete();
      end
      if (o[12] && !prev_pclk[d] && o[10]) begin
        if (d == 0) cap0.push_back(o[7:0]); else cap1.push_back(o[7:0]);
      end
      if (d == 0) begin
        cnt_fs   += int'(o[9]);
        cnt_vs   += int'(o[11]);
        cnt_href += int'(o[10]);
        cnt_tog  += int'(o[12] != prev_pclk[0]);
      end
      prev_pclk[d] = o[12];
    end
  endtask

  task automatic wait_fs(int d, int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      clr_cnt();
      cyc();
      seen = get_out(d)[9];
    end
    chk("wait_frame_start", d, 16'(seen), 16'd1);
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; solid_color = 16'h0000;
    prev_pclk[0] = 1'b0; prev_pclk[1] = 1'b0;
    model_reset();
    clr_cnt();

    // 1. reset state, then idle with a free-running pclk
    repeat (3) cyc();
    chk("reset_outputs", 0, 16'(get_out(0)), 16'h0000);
    chk("reset_outputs", 1, 16'(get_out(1)), 16'h0000);
    rst_n = 1'b1;
    clr_cnt();
    repeat (100) cyc();
    chk("idle_pclk_toggles", 0, 16'(cnt_tog), 16'd100);
    chk("idle_vsync_clks", 0, 16'(cnt_vs), 16'd0);
    chk("idle_href_clks", 0, 16'(cnt_href), 16'd0);

    // 2. solid colour frame on geometry A
    en = 1'b1; mode = 2'd0; solid_color = 16'hABCD;
    wait_fs(0, 20);
    repeat (279) cyc();
    chk("frame_start_count", 0, 16'(cnt_fs), 16'd1);
    chk("vsync_clks", 0, 16'(cnt_vs), 16'd40);
    chk("href_clks", 0, 16'(cnt_href), 16'd128);
    chk("solid_bytes", 0, 16'(cap0.size()), 16'd64);
    chk("solid_b0", 0, 16'(capb(0, 0)), 16'h00AB);
    chk("solid_b1", 0, 16'(capb(0, 1)), 16'h00CD);
    chk("solid_b63", 0, 16'(capb(0, 63)), 16'h00CD);

    // 3. colour bars on geometry A
    mode = 2'd1;
    wait_fs(0, 20);
    repeat (279) cyc();
    for (int i = 0; i < 16; i++) begin
      chk("bars_line0", 0, 16'(capb(0, i)), 16'(bars_lit[i]));
      chk("bars_line3", 0, 16'(capb(0, 48 + i)), 16'(bars_lit[i]));
    end

    // 4. checker, then ramp, on geometry B (32 bytes per line)
    mode = 2'd3;
    wait_fs(1, 3000);
    repeat (2735) cyc();
    chk("check_bytes", 1, 16'(cap1.size()), 16'd512);
    chk("check_x7_y0", 1, 16'(capb(1, 14)), 16'h0000);
    chk("check_x8_y0", 1, 16'(capb(1, 16)), 16'h00FF);
    chk("check_x0_y8", 1, 16'(capb(1, 8 * 32)), 16'h00FF);
    chk("check_x8_y8", 1, 16'(capb(1, 8 * 32 + 16)), 16'h0000);
    chk("check_x15_y8_lo", 1, 16'(capb(1, 8 * 32 + 31)), 16'h0000);
    mode = 2'd2;
    wait_fs(1, 3000);
    repeat (2735) cyc();
    chk("ramp_x0_hi", 1, 16'(capb(1, 0)), 16'h0000);
    chk("ramp_x5_lo", 1, 16'(capb(1, 11)), 16'h0005);
    chk("ramp_x15_hi", 1, 16'(capb(1, 30)), 16'h0000);
    chk("ramp_x15_lo", 1, 16'(capb(1, 31)), 16'h000F);
    chk("ramp_y1_x15_lo", 1, 16'(capb(1, 63)), 16'h000F);

    // 5. drop en and change mode in active line 2: frame completes unchanged
    mode = 2'd0; solid_color = 16'h1234;
    wait_fs(0, 300);
    repeat (165) cyc();
    chk("mid_frame_href", 0, 16'(get_out(0)[10]), 16'd1);
    en = 1'b0; mode = 2'd2; solid_color = 16'h0000;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cyc();
      seen = !get_out(0)[8];
    end
    chk("busy_drops", 0, 16'(seen), 16'd1);
    chk("stop_bytes", 0, 16'(cap0.size()), 16'd64);
    chk("stop_last_byte", 0, 16'(capb(0, 63)), 16'h0034);
    repeat (20) cyc();
    chk("stays_idle", 0, 16'(get_out(0)[8]), 16'd0);

    // 6. reset during an active line, then a full frame after release
    en = 1'b1; mode = 2'd1;
    wait_fs(0, 300);
    repeat (100) cyc();
    chk("pre_reset_href", 0, 16'(get_out(0)[10]), 16'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_now_a", 0, 16'(get_out(0)), 16'h0000);
    chk("reset_now_b", 1, 16'(get_out(1)), 16'h0000);
    repeat (3) cyc();
    rst_n = 1'b1;
    wait_fs(0, 20);
    repeat (279) cyc();
    chk("post_reset_bytes", 0, 16'(cap0.size()), 16'd64);
    for (int i = 0; i < 16; i++)
      chk("post_reset_bars", 0, 16'(capb(0, 16 + i)), 16'(bars_lit[i]));

    // randomized run: en, mode and colour change at arbitrary times
    for (int it = 0; it < 40; it++) begin
      en          = ($urandom_range(0, 3) != 0);
      mode        = 2'($urandom_range(0, 3));
      solid_color = 16'($urandom);
      if ($urandom_range(0, 9) == 0) do_reset(2);
      repeat ($urandom_range(20, 200)) cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
